crc_serial_engine: RTL and testbench

Parametrised serial CRC engine, the successor to the fixed 5-bit message / 3-bit CRC generator. It divides MSB-first by a configurable polynomial and runs in one of two modes. Generate mode produces the codeword {msg, crc}. Check mode takes a received codeword and flags a nonzero remainder. It adds a valid/ready bit handshake, an output handshake, a clock-enable, and a synchronous abort. It sits between the serial pin interface and the output register bank of the top-level tile.

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_lfsr_step.sv | 21 ++
 rtl/crc_serial_engine.sv | 150 +++++++++++++++
 tb/tb_crc_serial_engine.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the serial CRC engine family.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MSG   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Generator polynomials written without the implicit top term.
    localparam logic [2:0]  CRC3_GSM    = 3'b011;
    localparam logic [7:0]  CRC8_ATM    = 8'h07;
    localparam logic [15:0] CRC16_CCITT = 16'h1021;

endpackage

// File: rtl/crc_lfsr_step.sv
// One MSB-first polynomial division step: shift in one bit and fold the
// polynomial back in when the bit falling off the top was set.
module crc_lfsr_step #(
    parameter int               CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = 3'b011
) (
    input  logic [CRC_W-1:0] crc_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_next_o
);

    logic feedback;

    assign feedback = crc_i[CRC_W-1];

    // Modulo-2 shift-and-subtract, truncated to CRC_W bits.
    always_comb begin
        crc_next_o = {crc_i[CRC_W-2:0], bit_i} ^ (feedback ? POLY : '0);
    end

endmodule

// File: rtl/crc_serial_engine.sv
// Serial CRC engine: generates {msg, crc} codewords or checks received
// codewords, with bit-level valid/ready in, result valid/ready out.
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int               MSG_W = 5,
    parameter int               CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = CRC3_GSM,
    parameter logic [CRC_W-1:0] INIT  = '0,
    parameter int               CW_W  = MSG_W + CRC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            abort,
    input  logic            mode,
    input  logic            bit_in,
    input  logic            bit_valid,
    output logic            bit_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW_W-1:0] codeword,
    output logic [CRC_W-1:0] crc_out,
    output logic            crc_err,
    output logic            busy
);

    localparam int              CNT_W      = $clog2(CW_W + 1);
    localparam logic [CNT_W-1:0] MSG_LAST   = CNT_W'(MSG_W);
    localparam logic [CNT_W-1:0] CW_LAST    = CNT_W'(CW_W);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(CRC_W - 1);

    state_e            state_q;
    logic              mode_q;
    logic [CRC_W-1:0]  crc_q;
    logic [CNT_W-1:0]  count_q;
    // The newest bit of a check-mode codeword comes straight from bit_in,
    // so only CW_W-1 earlier bits ever need to be stored.
    logic [CW_W-2:0]   data_q;
    logic              bitReady_q;
    logic              outValid_q;
    logic [CW_W-1:0]   codeword_q;
    logic [CRC_W-1:0]  crcOut_q;
    logic              crcErr_q;

    logic              stepBit;
    logic [CRC_W-1:0]  crcStep;
    logic              modeEff;
    logic [CNT_W-1:0]  countInc;
    logic              clearFrame;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc_i      (crc_q),
        .bit_i      (stepBit),
        .crc_next_o (crcStep)
    );

    // Per-cycle helpers: flush feeds zeros, the first bit of a frame takes the
    // live mode pin and restarts the count, and the counter saturates.
    always_comb begin
        stepBit    = (state_q == FLUSH) ? 1'b0 : bit_in;
        modeEff    = (state_q == IDLE) ? mode : mode_q;
        countInc   = count_q;
        if (state_q == IDLE) begin
            countInc = CNT_W'(1);
        end else if (count_q != CW_LAST) begin
            countInc = count_q + CNT_W'(1);
        end
        clearFrame = abort | ((state_q == DONE) & out_ready);
    end

    // Frame sequencer with registered handshake and result outputs; nothing
    // moves while en is low, and abort or a taken result restarts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_GEN;
            crc_q      <= INIT;
            count_q    <= '0;
            data_q     <= '0;
            bitReady_q <= 1'b1;
            outValid_q <= 1'b0;
            codeword_q <= '0;
            crcOut_q   <= '0;
            crcErr_q   <= 1'b0;
        end else if (en) begin
            if (clearFrame) begin
                state_q    <= IDLE;
                mode_q     <= MODE_GEN;
                crc_q      <= INIT;
                count_q    <= '0;
                data_q     <= '0;
                bitReady_q <= 1'b1;
                outValid_q <= 1'b0;
                codeword_q <= '0;
                crcOut_q   <= '0;
                crcErr_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, MSG: begin
                        if (bit_valid) begin
                            mode_q  <= modeEff;
                            crc_q   <= crcStep;
                            count_q <= countInc;
                            data_q  <= {data_q[CW_W-3:0], bit_in};
                            state_q <= MSG;
                            if ((modeEff == MODE_GEN) && (countInc == MSG_LAST)) begin
                                state_q    <= FLUSH;
                                count_q    <= '0;
                                bitReady_q <= 1'b0;
                            end else if ((modeEff == MODE_CHK) && (countInc == CW_LAST)) begin
                                state_q    <= DONE;
                                bitReady_q <= 1'b0;
                                outValid_q <= 1'b1;
                                codeword_q <= {data_q, bit_in};
                                crcOut_q   <= crcStep;
                                crcErr_q   <= |crcStep;
                            end
                        end
                    end
                    FLUSH: begin
                        crc_q   <= crcStep;
                        count_q <= countInc;
                        if (count_q == FLUSH_LAST) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                            codeword_q <= {data_q[MSG_W-1:0], crcStep};
                            crcOut_q   <= crcStep;
                            crcErr_q   <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                endcase
            end
        end
    end

    assign bit_ready = bitReady_q;
    assign out_valid = outValid_q;
    assign codeword  = codeword_q;
    assign crc_out   = crcOut_q;
    assign crc_err   = crcErr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_crc_serial_engine.sv
// Scoreboard bench for crc_serial_engine: a default 5/3 instance and an
// 8/8 CRC-8/ATM instance, with hand-computed expected results.
module tb_crc_serial_engine;
    import crc_pkg::*;

    typedef struct {
        logic [7:0] cw;
        logic [2:0] crc;
        logic       err;
    } expA_t;

    typedef struct {
        logic [15:0] cw;
        logic [7:0]  crc;
        logic        err;
    } expB_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       enA = 1'b1, abortA = 1'b0, modeA = 1'b0, bitInA = 1'b0, bitValidA = 1'b0;
    logic       outReadyA = 1'b1;
    logic       bitReadyA, outValidA, crcErrA, busyA;
    logic [7:0] codewordA;
    logic [2:0] crcOutA;

    logic        enB = 1'b1, abortB = 1'b0, modeB = 1'b0, bitInB = 1'b0, bitValidB = 1'b0;
    logic        outReadyB = 1'b1;
    logic        bitReadyB, outValidB, crcErrB, busyB;
    logic [15:0] codewordB;
    logic [7:0]  crcOutB;

    expA_t expA[$];
    expB_t expB[$];

    int checks = 0;
    int errors = 0;

    crc_serial_engine dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (enA),
        .abort     (abortA),
        .mode      (modeA),
        .bit_in    (bitInA),
        .bit_valid (bitValidA),
        .bit_ready (bitReadyA),
        .out_valid (outValidA),
        .out_ready (outReadyA),
        .codeword  (codewordA),
        .crc_out   (crcOutA),
        .crc_err   (crcErrA),
        .busy      (busyA)
    );

    crc_serial_engine #(
        .MSG_W (8),
        .CRC_W (8),
        .POLY  (CRC8_ATM)
    ) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (enB),
        .abort     (abortB),
        .mode      (modeB),
        .bit_in    (bitInB),
        .bit_valid (bitValidB),
        .bit_ready (bitReadyB),
        .out_valid (outValidB),
        .out_ready (outReadyB),
        .codeword  (codewordB),
        .crc_out   (crcOutB),
        .crc_err   (crcErrB),
        .busy      (busyB)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop in case anything stalls indefinitely.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point; every check in the bench lands here.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Offers one bit to dutA, optionally preceded by random stall cycles
    // (en low, or valid low with a wrong bit), until it is accepted.
    task automatic sendBitA(input logic b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 1) == 1) begin
                    enA = 1'b0; bitValidA = 1'b1;
                end else begin
                    enA = 1'b1; bitValidA = 1'b0;
                end
                bitInA = ~b;
                @(posedge clk); #1;
            end
        end
        enA = 1'b1; bitInA = b; bitValidA = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (enA && bitReadyA) begin
                @(posedge clk); #1;
                bitValidA = 1'b0;
                return;
            end
        end
        bitValidA = 1'b0;
        checkOutput("A.bitAcceptTimeout", 1, 0);
    endtask

    // Offers one bit to dutB until it is accepted.
    task automatic sendBitB(input logic b);
        bitInB = b; bitValidB = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (enB && bitReadyB) begin
                @(posedge clk); #1;
                bitValidB = 1'b0;
                return;
            end
        end
        bitValidB = 1'b0;
        checkOutput("B.bitAcceptTimeout", 1, 0);
    endtask

    // Sends the low n bits of 'bits' MSB first to dutA in the given mode.
    task automatic applyStimulusA(input logic m, input logic [7:0] bits, input int n, input bit gaps);
        modeA = m;
        for (int i = n - 1; i >= 0; i--) begin
            sendBitA(bits[i], gaps);
        end
    endtask

    // Sends the low n bits of 'bits' MSB first to dutB in the given mode.
    task automatic applyStimulusB(input logic m, input logic [15:0] bits, input int n);
        modeB = m;
        for (int i = n - 1; i >= 0; i--) begin
            sendBitB(bits[i]);
        end
    endtask

    // Waits a bounded number of cycles for dutA to present a result.
    task automatic waitValidA(input string name);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (outValidA) return;
        end
        checkOutput(name, 0, 1);
    endtask

    // Monitor for dutA: compare each taken result against the next expectation.
    always @(negedge clk) begin : monA
        expA_t e;
        if (rst_n && enA && outValidA && outReadyA) begin
            if (expA.size() == 0) begin
                checkOutput("A.unexpectedResult", {24'd0, codewordA}, 32'hFFFF_FFFF);
            end else begin
                e = expA.pop_front();
                checkOutput("A.codeword", {24'd0, codewordA}, {24'd0, e.cw});
                checkOutput("A.crc_out", {29'd0, crcOutA}, {29'd0, e.crc});
                checkOutput("A.crc_err", {31'd0, crcErrA}, {31'd0, e.err});
            end
        end
    end

    // Monitor for dutB: compare each taken result against the next expectation.
    always @(negedge clk) begin : monB
        expB_t e;
        if (rst_n && enB && outValidB && outReadyB) begin
            if (expB.size() == 0) begin
                checkOutput("B.unexpectedResult", {16'd0, codewordB}, 32'hFFFF_FFFF);
            end else begin
                e = expB.pop_front();
                checkOutput("B.codeword", {16'd0, codewordB}, {16'd0, e.cw});
                checkOutput("B.crc_out", {24'd0, crcOutB}, {24'd0, e.crc});
                checkOutput("B.crc_err", {31'd0, crcErrB}, {31'd0, e.err});
            end
        end
    end

    // Directed sequence.
    initial begin
        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        checkOutput("rst.bit_ready", {31'd0, bitReadyA}, 1);
        checkOutput("rst.out_valid", {31'd0, outValidA}, 0);
        checkOutput("rst.codeword", {24'd0, codewordA}, 0);
        checkOutput("rst.crc_out", {29'd0, crcOutA}, 0);
        checkOutput("rst.busy", {31'd0, busyA}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Generate 11010: codeword D2, crc 010, valid after exactly 3 flush cycles.
        expA.push_back('{cw: 8'hD2, crc: 3'b010, err: 1'b0});
        applyStimulusA(MODE_GEN, 8'b11010, 5, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("gen.latency%0d", i), {31'd0, outValidA}, (i == 4) ? 1 : 0);
            if (i < 4) checkOutput($sformatf("gen.flushReady%0d", i), {31'd0, bitReadyA}, 0);
        end
        @(posedge clk); #1;

        // Check good word D2: valid right after the 8th bit, zero remainder.
        expA.push_back('{cw: 8'hD2, crc: 3'b000, err: 1'b0});
        applyStimulusA(MODE_CHK, 8'hD2, 8, 1'b0);
        @(negedge clk);
        checkOutput("chk.latency", {31'd0, outValidA}, 1);
        @(posedge clk); #1;

        // Check corrupted word D3: remainder 001, error flagged.
        expA.push_back('{cw: 8'hD3, crc: 3'b001, err: 1'b1});
        applyStimulusA(MODE_CHK, 8'hD3, 8, 1'b0);
        waitValidA("chkBad.timeout");
        @(posedge clk); #1;

        // Zero-remainder message 10110 -> B0, result held while out_ready is low.
        outReadyA = 1'b0;
        expA.push_back('{cw: 8'hB0, crc: 3'b000, err: 1'b0});
        applyStimulusA(MODE_GEN, 8'b10110, 5, 1'b0);
        waitValidA("hold.timeout");
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold.out_valid", {31'd0, outValidA}, 1);
            checkOutput("hold.codeword", {24'd0, codewordA}, 32'hB0);
            checkOutput("hold.bit_ready", {31'd0, bitReadyA}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        outReadyA = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("hold.releasedValid", {31'd0, outValidA}, 0);
        checkOutput("hold.releasedReady", {31'd0, bitReadyA}, 1);
        checkOutput("hold.releasedBusy", {31'd0, busyA}, 0);
        @(posedge clk); #1;

        // Random en/valid gaps during 11010, plus en low across part of FLUSH.
        expA.push_back('{cw: 8'hD2, crc: 3'b010, err: 1'b0});
        applyStimulusA(MODE_GEN, 8'b11010, 5, 1'b1);
        enA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("gapFlush.busy", {31'd0, busyA}, 1);
            checkOutput("gapFlush.out_valid", {31'd0, outValidA}, 0);
        end
        @(posedge clk); #1;
        enA = 1'b1;
        waitValidA("gap.timeout");
        @(posedge clk); #1;

        // Abort after three bits, then a clean frame must give the clean result.
        applyStimulusA(MODE_GEN, 8'b110, 3, 1'b0);
        abortA = 1'b1;
        @(posedge clk); #1;
        abortA = 1'b0;
        @(negedge clk);
        checkOutput("abort.busy", {31'd0, busyA}, 0);
        checkOutput("abort.bit_ready", {31'd0, bitReadyA}, 1);
        @(posedge clk); #1;
        expA.push_back('{cw: 8'hD2, crc: 3'b010, err: 1'b0});
        applyStimulusA(MODE_GEN, 8'b11010, 5, 1'b0);
        waitValidA("postAbort.timeout");
        @(posedge clk); #1;

        // Reset dropped mid-FLUSH: everything returns to reset values at once.
        applyStimulusA(MODE_GEN, 8'b11010, 5, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst.busy", {31'd0, busyA}, 0);
        checkOutput("midRst.out_valid", {31'd0, outValidA}, 0);
        checkOutput("midRst.codeword", {24'd0, codewordA}, 0);
        checkOutput("midRst.crc_out", {29'd0, crcOutA}, 0);
        checkOutput("midRst.crc_err", {31'd0, crcErrA}, 0);
        checkOutput("midRst.bit_ready", {31'd0, bitReadyA}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame after reset checks the CRC register restarted from INIT.
        expA.push_back('{cw: 8'hD2, crc: 3'b000, err: 1'b0});
        applyStimulusA(MODE_CHK, 8'hD2, 8, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;

        // CRC-8/ATM of 0x31 is 0x97; the codeword 3197 checks clean and a
        // flipped last bit leaves remainder 01.
        expB.push_back('{cw: 16'h3197, crc: 8'h97, err: 1'b0});
        applyStimulusB(MODE_GEN, 16'h0031, 8);
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        expB.push_back('{cw: 16'h3197, crc: 8'h00, err: 1'b0});
        applyStimulusB(MODE_CHK, 16'h3197, 16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        expB.push_back('{cw: 16'h3196, crc: 8'h01, err: 1'b1});
        applyStimulusB(MODE_CHK, 16'h3196, 16);
        repeat (4) @(negedge clk);

        // Every expected result must have been taken.
        checkOutput("A.pendingExpected", expA.size(), 0);
        checkOutput("B.pendingExpected", expB.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
